// File: rtl/fixed_point_pkg.sv
`default_nettype none
// =============================================================================
// fixed_point_pkg : shared constants and FSM encoding for the fixed-point divider
// Rev 1.0
// =============================================================================
package fixed_point_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_FRAC      = 16;
  localparam int DEF_QWIDTH    = DEF_WIDTH + DEF_FRAC;
  localparam int DEF_CNT_WIDTH = $clog2(DEF_QWIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/divider_fixed_point_step.sv
`default_nettype none
// =============================================================================
// divider_fixed_point_step : one restoring-division iteration (shift, compare, subtract)
// Rev 1.0
// =============================================================================
module divider_fixed_point_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  // rem[WIDTH] stays 0 while rem < divisor; folding it into ge keeps the full 2R+d meaning.
  assign shifted  = {rem[WIDTH-1:0], din};
  assign ge       = rem[WIDTH] | (shifted >= {1'b0, divisor});
  assign diff     = shifted - {1'b0, divisor};
  assign rem_next = ge ? diff : shifted;
  assign q_bit    = ge;

endmodule
`default_nettype wire

// File: rtl/divider_fixed_point.sv
`default_nettype none
// =============================================================================
// divider_fixed_point : radix-2 restoring unsigned QI.F divider, one quotient bit per
// falling clock edge. Optional round-to-nearest: DIVIDER_FIXED_POINT_ROUNDING_EN. Rev 1.0
// =============================================================================
module divider_fixed_point
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             dz,
  output logic             ovf
);

  localparam int QW = WIDTH + FRAC;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(QW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [QW-1:0]    dvd;
  logic [QW-1:0]    quo;
  logic [QW-1:0]    q_full;
  logic [QW-1:0]    a_ext;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] c_res;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_nx;
  logic [CW-1:0]    cnt;
  logic             q_bit;
  logic             accept;
  logic             last;
  logic             ovf_res;
  logic             b_zero;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CNT_ONE);
  assign b_zero = (B == '0);
  assign a_ext  = QW'(A) << FRAC;

  divider_fixed_point_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem),
    .din      (dvd[QW-1]),
    .divisor  (dvs),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  assign q_full = (quo << 1) | QW'(q_bit);

`ifdef DIVIDER_FIXED_POINT_ROUNDING_EN
  // Ties round away from zero; the extra MSB catches a carry out of the full quotient.
  logic [QW:0] q_res;
  logic        rnd_up;
  assign rnd_up = ({rem_nx, 1'b0} >= {2'b00, dvs});
  assign q_res  = {1'b0, q_full} + {{QW{1'b0}}, rnd_up};
`else
  logic [QW-1:0] q_res;
  assign q_res = q_full;
`endif

  assign ovf_res = |(q_res >> WIDTH);
  assign c_res   = ovf_res ? '1 : q_res[WIDTH-1:0];

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = b_zero ? DONE : CALC;
      CALC:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    if ((state == IDLE) && !rst) in_ready = 1'b1;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      C         <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (b_zero) begin
              C         <= '1;
              dz        <= 1'b1;
              ovf       <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              dvd <= a_ext;
              dvs <= B;
              rem <= '0;
              quo <= '0;
              cnt <= CNT_INIT;
              dz  <= 1'b0;
              ovf <= 1'b0;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= q_full;
          dvd <= dvd << 1;
          cnt <= cnt - CNT_ONE;
          if (last) begin
            C         <= c_res;
            ovf       <= ovf_res;
            dz        <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_fixed_point.sv
`default_nettype none
// =============================================================================
// tb_divider_fixed_point : directed + randomized checks of divider_fixed_point (Q16.16)
// Rev 1.0
// =============================================================================
module tb_divider_fixed_point;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int QW    = WIDTH + FRAC;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  C;
  logic              dz;
  logic              ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divider_fixed_point #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .dz        (dz),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer division of A*2^FRAC by B, then rounding/saturation.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] c, output logic z, output logic o);
    logic [63:0] n;
    logic [63:0] q;
    logic [63:0] r;
    c = '0;
    z = 1'b0;
    o = 1'b0;
    if (b == 32'h0) begin
      c = '1;
      z = 1'b1;
    end else begin
      n = {16'h0, a, 16'h0};
      q = n / {32'h0, b};
      r = n % {32'h0, b};
`ifdef DIVIDER_FIXED_POINT_ROUNDING_EN
      if ((r << 1) >= {32'h0, b}) q = q + 64'd1;
`else
      r = 64'd0;
`endif
      if (q >= 64'h1_0000_0000) begin
        c = '1;
        o = 1'b1;
      end else begin
        c = q[31:0];
      end
    end
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, output logic [31:0] c_obs);
    logic [31:0] ec;
    logic        ez;
    logic        eo;
    int          lat;
    ref_div(a, b, ec, ez, eo);
    check("in_ready_idle", in_ready, 1);
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge clk);
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    // Counted in sampling points after the accepting falling edge.
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
    end
    check("latency", lat, (b == 32'h0) ? 1 : QW + 1);
    check("C", C, ec);
    check("dz", dz, ez);
    check("ovf", ovf, eo);
    check("in_ready_busy", in_ready, 0);
    c_obs     = C;
    out_ready = 1'b1;
    @(posedge clk);
    out_ready = 1'b0;
    check("out_valid_clr", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    logic [31:0] c;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    int          w;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_C", C, 0);
    check("rst_dz", dz, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);

    run_div(32'h0003_0000, 32'h0002_0000, c);
    check("plan_3_div_2", c, 32'h0001_8000);
    run_div(32'h0002_0000, 32'h0003_0000, c);
`ifdef DIVIDER_FIXED_POINT_ROUNDING_EN
    check("plan_2_div_3", c, 32'h0000_AAAB);
`else
    check("plan_2_div_3", c, 32'h0000_AAAA);
`endif
    run_div(32'h0001_0000, 32'h0000_0000, c);
    check("plan_div_zero", c, 32'hFFFF_FFFF);
    run_div(32'h0001_0000, 32'h0000_0001, c);
    check("plan_overflow", c, 32'hFFFF_FFFF);
    run_div(32'h0000_0000, 32'h0001_2345, c);
    check("zero_dividend", c, 32'h0);

    // Backpressure: result held while out_ready is low, new requests ignored.
    A        = 32'h0003_0000;
    B        = 32'h0002_0000;
    in_valid = 1'b1;
    @(posedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 200) begin
      @(posedge clk);
      w++;
    end
    check("bp_reach_done", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      A        = $urandom;
      B        = $urandom;
      @(posedge clk);
      check("bp_C_hold", C, 32'h0001_8000);
      check("bp_flags_hold", {out_valid, dz, ovf, in_ready}, 4'b1000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk);
    check("bp_no_phantom", {out_valid, in_ready}, 2'b01);

    // Reset in the middle of CALC.
    A        = 32'h0005_0000;
    B        = 32'h0000_3000;
    in_valid = 1'b1;
    @(posedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("calc_rst_C", C, 0);
    check("calc_rst_flags", {out_valid, dz, ovf}, 3'b000);
    @(posedge clk);
    rst = 1'b0;
    #1;
    check("calc_rst_ready", in_ready, 1);
    @(posedge clk);
    run_div(32'h0003_0000, 32'h0002_0000, c);
    check("after_rst_3_div_2", c, 32'h0001_8000);

    // Reset while a divide-by-zero result is held.
    A        = 32'h0000_1234;
    B        = 32'h0;
    in_valid = 1'b1;
    @(posedge clk);
    in_valid = 1'b0;
    check("dz_held_valid", {out_valid, dz}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("done_rst_C", C, 0);
    check("done_rst_flags", {out_valid, dz, ovf}, 3'b000);
    @(posedge clk);
    rst = 1'b0;
    @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        ra = $urandom;
        rb = 32'h0;
      end else if (sel < 4) begin
        ra = $urandom;
        rb = $urandom;
      end else if (sel < 8) begin
        ra = $urandom_range(0, 32'h00FF_FFFF);
        rb = $urandom_range(1, 32'h00FF_FFFF);
      end else begin
        ra = $urandom;
        rb = $urandom_range(1, 16);
      end
      run_div(ra, rb, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
